// File: rtl/spi_target.sv
// Purpose : SPI mode-0 target exposing an NREGS x DATA_W register bank to a remote
//           initiator, with burst writes/reads and address auto-increment.
// Latency : 3 clk from pin edge to internal event; write commits 1 clk after the
//           8th rise is detected; miso updates 1 clk after the detected edge.
// Backpressure: none. The initiator paces everything through sclk, and sclk
//           half-periods must be at least 4 clk.
//
// Ports:
//   i_clk, i_reset     system clock, synchronous active-high reset
//   i_sclk, i_ss       SPI clock (idle low) and active-low select, asynchronous
//   i_mosi / o_miso    serial data in / out, MSB first
//   i_loc_addr         local read address; o_loc_rdata = regs[i_loc_addr]
//   o_wr_valid         one-clk strobe per committed SPI write, with o_wr_addr/o_wr_data
//   o_busy             synchronized ss is low
//   o_spi_irq          end-of-frame pulse for frames that wrote something
//
// Optional feature macro: SPI_TGT_IRQ_EN builds the end-of-frame interrupt.
// When it is undefined, o_spi_irq is tied to 0.

module spi_target #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 8,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sclk,
    input  logic              i_ss,
    input  logic              i_mosi,
    output logic              o_miso,
    input  logic [AW-1:0]     i_loc_addr,
    output logic [DATA_W-1:0] o_loc_rdata,
    output logic              o_wr_valid,
    output logic [AW-1:0]     o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_spi_irq
);

    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_SS
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Input synchronizers and edge history.
    // These are left out of reset on purpose. The reset decision (IDLE or
    // WAIT_SS) must see the true ss level. Resetting the chain would also
    // fake an ss edge when reset is released in the middle of a frame.
    // ------------------------------------------------------------------
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_ss_s1,   r_ss_s2,   r_ss_d;
    logic r_mosi_s1, r_mosi_s2;

    always_ff @(posedge i_clk) begin
        r_sclk_s1 <= i_sclk;
        r_sclk_s2 <= r_sclk_s1;
        r_sclk_d  <= r_sclk_s2;
        r_ss_s1   <= i_ss;
        r_ss_s2   <= r_ss_s1;
        r_ss_d    <= r_ss_s2;
        r_mosi_s1 <= i_mosi;
        r_mosi_s2 <= r_mosi_s1;
    end

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_ss_rise   = r_ss_s2 & ~r_ss_d;
    assign w_ss_fall   = ~r_ss_s2 & r_ss_d;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [BW-1:0]     r_bitcnt;
    logic [DATA_W-2:0] r_rx_sr;     // bits received so far; the byte completes with mosi
    logic [DATA_W-2:0] r_tx_sr;     // bits still to send; the MSB goes straight to miso
    logic [AW-1:0]     r_addr;
    logic              r_miso;
    logic              r_wr_valid;
    logic [AW-1:0]     r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic [DATA_W-1:0] w_rx_byte;
    logic              w_last_bit;
    logic              w_cmd_rw;
    logic [DATA_W-2:AW] w_cmd_rsv;
    logic [AW-1:0]     w_cmd_addr;

    assign w_rx_byte  = {r_rx_sr, r_mosi_s2};
    assign w_last_bit = w_sclk_rise && (r_bitcnt == BW'(DATA_W - 1));
    assign w_cmd_rw   = w_rx_byte[DATA_W-1];
    assign w_cmd_rsv  = w_rx_byte[DATA_W-2:AW];
    assign w_cmd_addr = w_rx_byte[AW-1:0];

    // Control strobes from the FSM to the datapath
    logic w_clr_cnt;
    logic w_shift_rx;
    logic w_cmd_wr;
    logic w_cmd_rd;
    logic w_commit;
    logic w_rd_reload;
    logic w_tx_shift;
    logic w_miso_clr;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // A reset in the middle of a frame idles until the initiator
            // ends the frame, so the leftover bytes are never interpreted.
            r_state <= r_ss_s2 ? ST_IDLE : ST_WAIT_SS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_clr_cnt   = 1'b0;
        w_shift_rx  = 1'b0;
        w_cmd_wr    = 1'b0;
        w_cmd_rd    = 1'b0;
        w_commit    = 1'b0;
        w_rd_reload = 1'b0;
        w_tx_shift  = 1'b0;
        w_miso_clr  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_miso_clr = 1'b1;
                if (w_ss_fall) begin
                    w_clr_cnt   = 1'b1;
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_sclk_rise) begin
                    w_shift_rx = 1'b1;
                    if (w_last_bit) begin
                        if (w_cmd_rsv != '0) begin
                            w_state_nxt = ST_WAIT_SS;
                        end else if (w_cmd_rw) begin
                            w_cmd_wr    = 1'b1;
                            w_state_nxt = ST_WDATA;
                        end else begin
                            w_cmd_rd    = 1'b1;
                            w_state_nxt = ST_RDATA;
                        end
                    end
                end
            end
            ST_WDATA: begin
                if (w_sclk_rise) begin
                    w_shift_rx = 1'b1;
                    w_commit   = w_last_bit;
                end
            end
            ST_RDATA: begin
                if (w_sclk_rise) begin
                    w_shift_rx  = 1'b1;
                    w_rd_reload = w_last_bit;
                end
                // The fall right after a byte boundary (bitcnt back at 0)
                // must leave the freshly loaded MSB on miso. Only the falls
                // after bits 1..7 advance the shifter.
                if (w_sclk_fall && (r_bitcnt != '0)) begin
                    w_tx_shift = 1'b1;
                end
            end
            ST_WAIT_SS: begin
                w_miso_clr = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // End of frame wins over everything except the byte that completes
        // in this same cycle. That byte's commit strobe is left untouched.
        if (w_ss_rise) begin
            w_state_nxt = ST_IDLE;
            w_miso_clr  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bitcnt   <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_addr     <= '0;
            r_miso     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_valid <= w_commit;

            if (w_clr_cnt) begin
                r_bitcnt <= '0;
            end else if (w_shift_rx) begin
                r_bitcnt <= w_last_bit ? '0 : r_bitcnt + 1'b1;
            end

            if (w_shift_rx) begin
                r_rx_sr <= w_rx_byte[DATA_W-2:0];
            end

            if (w_cmd_wr) begin
                r_addr <= w_cmd_addr;
            end

            if (w_cmd_rd) begin
                r_tx_sr <= r_regs[w_cmd_addr][DATA_W-2:0];
                r_addr  <= w_cmd_addr + 1'b1;
            end

            if (w_commit) begin
                r_regs[r_addr] <= w_rx_byte;
                r_wr_addr      <= r_addr;
                r_wr_data      <= w_rx_byte;
                r_addr         <= r_addr + 1'b1;
            end

            if (w_rd_reload) begin
                r_tx_sr <= r_regs[r_addr][DATA_W-2:0];
                r_addr  <= r_addr + 1'b1;
            end

            if (w_tx_shift) begin
                r_tx_sr <= {r_tx_sr[DATA_W-3:0], 1'b0};
            end

            if (w_miso_clr) begin
                r_miso <= 1'b0;
            end else if (w_cmd_rd) begin
                r_miso <= r_regs[w_cmd_addr][DATA_W-1];
            end else if (w_rd_reload) begin
                r_miso <= r_regs[r_addr][DATA_W-1];
            end else if (w_tx_shift) begin
                r_miso <= r_tx_sr[DATA_W-2];
            end
        end
    end

    // ------------------------------------------------------------------
    // End-of-frame interrupt
    // ------------------------------------------------------------------
`ifdef SPI_TGT_IRQ_EN
    logic r_wr_seen;
    logic r_irq;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_seen <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            // Include a write that commits in the same cycle as ss rising.
            r_irq <= w_ss_rise & (r_wr_seen | w_commit);
            if (w_ss_rise) begin
                r_wr_seen <= 1'b0;
            end else if (w_commit) begin
                r_wr_seen <= 1'b1;
            end
        end
    end

    assign o_spi_irq = r_irq;
`else
    assign o_spi_irq = 1'b0;
`endif

    assign o_miso      = r_miso;
    assign o_loc_rdata = r_regs[i_loc_addr];
    assign o_wr_valid  = r_wr_valid;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = ~r_ss_s2;

endmodule

// File: tb/tb_spi_target.sv
`timescale 1ns/1ps
module tb_spi_target;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       sclk  = 1'b0;
    logic       ss    = 1'b1;
    logic       mosi  = 1'b0;
    logic       miso;
    logic [2:0] loc_addr = 3'd0;
    logic [7:0] loc_rdata;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       spi_irq;

    always #5 clk = ~clk;

    spi_target dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_sclk      (sclk),
        .i_ss        (ss),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .i_loc_addr  (loc_addr),
        .o_loc_rdata (loc_rdata),
        .o_wr_valid  (wr_valid),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_busy      (busy),
        .o_spi_irq   (spi_irq)
    );

    int total = 0;
    int bad   = 0;
    int half  = 6;              // sclk half-period in clk cycles

    typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;

    logic [7:0] fb  [8];        // bytes of the frame being sent
    logic [7:0] rxb [8];        // miso bytes seen during that frame
    logic [7:0] mdl [8];        // reference register bank
    wr_t        got_wr[$];
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    int         irq_cnt = 0;
    wr_t        mon_w;

    // Write/irq monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (wr_valid) begin
            mon_w.a = wr_addr;
            mon_w.d = wr_data;
            got_wr.push_back(mon_w);
        end
        if (spi_irq) irq_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int irq_exp(input int nwr);
`ifdef SPI_TGT_IRQ_EN
        return (nwr > 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Shift out nbits of tx MSB first (mode 0) and capture miso before each rise
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (half) @(negedge clk);
            rx   = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nb, input int xb);
        logic [7:0] r;
        ss = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            xfer_bits(fb[i], 8, r);
            rxb[i] = r;
        end
        if (xb > 0) xfer_bits(fb[nb], xb, r);
        repeat (3) @(negedge clk);
        ss = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Frame-level reference: command byte then whole data bytes, with partial bytes dropped
    task automatic model_frame(input int nb);
        logic [7:0] c;
        logic [2:0] a;
        wr_t        w;
        c = fb[0];
        a = c[2:0];
        exp_wr.delete();
        exp_rd.delete();
        exp_rd.push_back(8'h00);
        for (int i = 1; i < nb; i++) begin
            if (c[6:3] != 4'd0) begin
                exp_rd.push_back(8'h00);
            end else if (c[7]) begin
                mdl[a] = fb[i];
                w.a = a;
                w.d = fb[i];
                exp_wr.push_back(w);
                exp_rd.push_back(8'h00);
                a = a + 3'd1;
            end else begin
                exp_rd.push_back(mdl[a]);
                a = a + 3'd1;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 8; a++) begin
            loc_addr = 3'(a);
            #1;
            chk($sformatf("%s reg%0d", tag, a), loc_rdata, mdl[a]);
        end
    endtask

    task automatic check_frame(input string tag, input int wb, input int ib, input int nb);
        chk($sformatf("%s nwr", tag), got_wr.size() - wb, exp_wr.size());
        for (int i = 0; i < exp_wr.size() && (wb + i) < got_wr.size(); i++) begin
            chk($sformatf("%s wr%0d addr", tag, i), got_wr[wb+i].a, exp_wr[i].a);
            chk($sformatf("%s wr%0d data", tag, i), got_wr[wb+i].d, exp_wr[i].d);
        end
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("%s miso byte%0d", tag, i), rxb[i], exp_rd[i]);
        end
        chk($sformatf("%s irq", tag), irq_cnt - ib, irq_exp(exp_wr.size()));
        check_regs(tag);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        int         nb, xb, nwr;
        logic [2:0] wa0;
        logic [7:0] wd0;
        logic [2:0] ca;
        logic [7:0] cd;
        logic [7:0] rd0, rd1;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [7:0] b0, b1, b2, b3, input int nb, xb, nwr,
                           input logic [2:0] wa0, input logic [7:0] wd0,
                           input logic [2:0] ca, input logic [7:0] cd,
                           input logic [7:0] rd0, rd1);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
        v.nb = nb; v.xb = xb; v.nwr = nwr;
        v.wa0 = wa0; v.wd0 = wd0; v.ca = ca; v.cd = cd; v.rd0 = rd0; v.rd1 = rd1;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t       v;
        int         wb, ib, nb, xb;
        logic [7:0] r, c;

        for (int a = 0; a < 8; a++) mdl[a] = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst miso", miso, 0);
        chk("rst wr_valid", wr_valid, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst busy", busy, 0);
        chk("rst irq", spi_irq, 0);
        check_regs("rst");

        // Directed frames: bytes, full bytes, extra bits, #writes, first write,
        // a register to check afterwards, miso during data bytes 1 and 2
        add_vec(8'h83, 8'hA5, 8'h00, 8'h00, 2, 0, 1, 3'd3, 8'hA5, 3'd3, 8'hA5, 8'h00, 8'h00);
        add_vec(8'h86, 8'h11, 8'h22, 8'h33, 4, 0, 3, 3'd6, 8'h11, 3'd0, 8'h33, 8'h00, 8'h00);
        add_vec(8'h84, 8'h5A, 8'h00, 8'h00, 2, 0, 1, 3'd4, 8'h5A, 3'd4, 8'h5A, 8'h00, 8'h00);
        add_vec(8'h03, 8'h00, 8'h00, 8'h00, 3, 0, 0, 3'd0, 8'h00, 3'd3, 8'hA5, 8'hA5, 8'h5A);
        add_vec(8'h81, 8'hFF, 8'h00, 8'h00, 1, 4, 0, 3'd0, 8'h00, 3'd1, 8'h00, 8'h00, 8'h00);
        add_vec(8'h81, 8'h3C, 8'h00, 8'h00, 2, 0, 1, 3'd1, 8'h3C, 3'd1, 8'h3C, 8'h00, 8'h00);
        add_vec(8'h90, 8'h82, 8'h44, 8'h00, 3, 0, 0, 3'd0, 8'h00, 3'd2, 8'h00, 8'h00, 8'h00);
        add_vec(8'h07, 8'h00, 8'h00, 8'h00, 3, 0, 0, 3'd0, 8'h00, 3'd7, 8'h22, 8'h22, 8'h33);

        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            fb[0] = v.b0; fb[1] = v.b1; fb[2] = v.b2; fb[3] = v.b3; fb[4] = 8'h00;
            wb = got_wr.size();
            ib = irq_cnt;
            model_frame(v.nb);
            run_frame(v.nb, v.xb);
            chk($sformatf("vec%0d nwr", k), got_wr.size() - wb, v.nwr);
            if (v.nwr > 0 && got_wr.size() > wb) begin
                chk($sformatf("vec%0d wr_addr", k), got_wr[wb].a, v.wa0);
                chk($sformatf("vec%0d wr_data", k), got_wr[wb].d, v.wd0);
            end
            loc_addr = v.ca;
            #1;
            chk($sformatf("vec%0d loc_rdata", k), loc_rdata, v.cd);
            if (v.nb >= 2) chk($sformatf("vec%0d rd0", k), rxb[1], v.rd0);
            if (v.nb >= 3) chk($sformatf("vec%0d rd1", k), rxb[2], v.rd1);
            chk($sformatf("vec%0d irq", k), irq_cnt - ib, irq_exp(v.nwr));
            chk($sformatf("vec%0d busy idle", k), busy, 0);
        end

        // Reset in the middle of a write data byte: regs cleared, rest of frame ignored
        wb = got_wr.size();
        ib = irq_cnt;
        ss = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst busy", busy, 1);
        xfer_bits(8'h80, 8, r);
        xfer_bits(8'hC3, 4, r);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst busy after", busy, 1);
        xfer_bits(8'h30, 4, r);
        chk("midrst miso tail", r, 8'h00);
        xfer_bits(8'h77, 8, r);
        chk("midrst miso byte", r, 8'h00);
        repeat (3) @(negedge clk);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        for (int a = 0; a < 8; a++) mdl[a] = 8'h00;
        chk("midrst nwr", got_wr.size() - wb, 0);
        chk("midrst irq", irq_cnt - ib, 0);
        check_regs("midrst");

        // ss rises in the same clk as the 8th data rise: the byte still commits
        wb = got_wr.size();
        ib = irq_cnt;
        ss = 1'b0;
        repeat (6) @(negedge clk);
        xfer_bits(8'h85, 8, r);
        xfer_bits(8'h6E, 7, r);
        mosi = 1'b0;
        repeat (half) @(negedge clk);
        sclk = 1'b1;
        ss   = 1'b1;
        repeat (half) @(negedge clk);
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        mdl[5] = 8'h6E;
        chk("coinc nwr", got_wr.size() - wb, 1);
        if (got_wr.size() > wb) begin
            chk("coinc wr_addr", got_wr[wb].a, 3'd5);
            chk("coinc wr_data", got_wr[wb].d, 8'h6E);
        end
        chk("coinc irq", irq_cnt - ib, irq_exp(1));
        check_regs("coinc");

        // Randomized frames against the reference model
        for (int f = 0; f < 40; f++) begin
            half = int'($urandom_range(7, 4));
            nb   = int'($urandom_range(5, 1));
            c    = 8'($urandom);
            if ($urandom_range(7, 0) != 0) c[6:3] = 4'd0;
            fb[0] = c;
            for (int i = 1; i < 8; i++) fb[i] = 8'($urandom);
            xb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
            wb = got_wr.size();
            ib = irq_cnt;
            model_frame(nb);
            run_frame(nb, xb);
            check_frame($sformatf("rnd%0d", f), wb, ib, nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI Mode 0 target (slave) that terminates the SPI link driven by the SoC `spi_controller`, presenting an 8-entry × 8-bit register bank to the remote initiator. It oversamples `sclk`/`ss`/`mosi` in the local `clk` domain, decodes a command byte, then performs burst register writes or reads with address auto-increment. Written registers are exported to local logic through a strobe port and a read port. It sits on the peripheral side of the board-level SPI link, or in the SoC testbench as the controller's loopback partner.

## Interface
- `DATA_W`, 8: register and shift width; command format fixed for 8.
- `NREGS`, 8: register count; address width is log2(`NREGS`) = 3.
- `clk` in 1: system clock, rising edge only.
- `reset` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock from initiator, asynchronous, idle low.
- `ss` in 1: slave select, active low, asynchronous.
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial data out, MSB first; reset 0.
- `loc_addr` in 3: local read address.
- `loc_rdata` out 8: `regs[loc_addr]`, combinational.
- `wr_valid` out 1: one-`clk` pulse per committed SPI write; reset 0.
- `wr_addr` out 3: address of committed write; reset 0.
- `wr_data` out 8: data of committed write; reset 0.
- `busy` out 1: high while the synchronized `ss` is low; reset 0.
- `spi_irq` out 1: end-of-frame pulse (see Configuration); reset 0.

## Operation
- Input sync: 2-FF synchronizers on `sclk`, `ss`, `mosi`, plus one history FF on `sclk`/`ss` for edge detection.
- Rise means a synchronized `sclk` 0→1 transition. Fall means 1→0.
- States:
  - IDLE: `miso`=0. On `ss` falling, clear `bitcnt`, go to CMD.
  - CMD: shift `mosi` on each rise. After 8 bits, the command byte is {rw, rsv[3:0], addr[2:0]}, where rw=1 means write.
    - If rsv≠0, go to WAIT_SS.
    - If rw=1, latch `addr` and go to WDATA.
    - If rw=0, latch `addr`, load `tx_sr`←`regs[addr]`, drive `miso`=`tx_sr[7]`, set `addr`←`addr`+1, and go to RDATA.
  - WDATA: shift on each rise. On the 8th bit, `regs[addr]`←byte, pulse `wr_valid` with `wr_addr`/`wr_data`, set `addr`←`addr`+1, clear `bitcnt`, and stay in WDATA.
  - RDATA: on each fall, shift `tx_sr` left and drive `miso`=new `tx_sr[7]`. On the 8th rise, reload `tx_sr`←`regs[addr]`, set `addr`+1, and stay in RDATA.
  - WAIT_SS: ignore `sclk`, hold `miso`=0, and wait for `ss` rising.
- Any state: `ss` rising returns to IDLE, discards any partial byte, and sets `miso`=0.
- Address wraps modulo 8, so 7 is followed by 0.
- Bytes completed before `ss` rising are already committed.

## Timing
- Pin-to-internal latency is 3 `clk` (2 sync stages plus the edge register).
- A write commits on the `clk` after the 8th rise is detected. `wr_valid` is high for exactly 1 cycle, and `loc_rdata` reflects the new value on the following cycle.
- The `miso` update follows a detected fall by 1 `clk`, or the command/data 8th rise by 1 `clk`. This must be at most 4 `clk` after the pin edge.
- Constraint: the `sclk` half-period must be at least 4 `clk` periods (`sclk` ≤ `clk`/8). Below this, behaviour is undefined.
- If `ss` rises in the same `clk` as a detected 8th rise, the byte completes and commits first, then the block goes to IDLE.
- `reset` mid-frame:
  - All registers clear to 0.
  - State goes to WAIT_SS if the synchronized `ss` is low, otherwise IDLE.
  - No `wr_valid` is issued for that frame.

## Configuration
- `SPI_TGT_IRQ_EN`:
  - Defined: `spi_irq` pulses high for 1 `clk` on the `ss` rising detection of any frame that committed at least one write.
  - Undefined: `spi_irq` is tied to 0 and the per-frame write-seen flag is not built.

## Test plan
- Write single: `ss` low, send 0x83, 0xA5, `ss` high → `wr_valid`×1 with `wr_addr`=3 and `wr_data`=0xA5; `loc_addr`=3 gives `loc_rdata`=0xA5.
- Burst wrap: send 0x86, 0x11, 0x22, 0x33 → `regs[6]`=0x11, `regs[7]`=0x22, `regs[0]`=0x33, with 3 `wr_valid` pulses.
- Read burst: preload `regs[3]`=0xA5 and `regs[4]`=0x5A, send 0x03 then 16 dummy clocks → `miso` shows 0xA5 then 0x5A, MSB first, with no `wr_valid`.
- Abort: send 0x81, then 4 bits of data, then `ss` high → `regs[1]` unchanged, no `wr_valid`, state IDLE, and the next frame works.
- Reserved/reset: command 0x90 → subsequent bytes ignored and `miso`=0. Separately, assert `reset` mid-WDATA → all regs 0, remaining bytes ignored until `ss` high.
- IRQ: with `SPI_TGT_IRQ_EN` defined, a write frame gives one `spi_irq` pulse and a read-only frame gives none. With the macro undefined, `spi_irq` stays 0.
